reg_dump_reader: RTL and testbench
==================================

# reg_dump_reader

Sequential read-side client of the processor's register file. It walks every register through one combinational read port of the register file and streams `(index, value)` pairs out over a valid/ready handshake. The block sits beside the decode stage and is used for debug and state dump. It only drives a read address and never writes the register file.

## Interface
- `WORD_LEN`, default 32, data word width (`WORD_LEN` in defines.v).
- `ADDR_LEN`, default 5, register address width (`REG_FILE_ADDR_LEN`).
- `REG_COUNT`, default 32, number of registers walked (`REG_FILE_SIZE`). Must be ≤ 2^`ADDR_LEN` and ≥ 1.
- Clock and reset (fixed): one clock, `clk`. Reset `rst` is asynchronous and active-low.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a dump; sampled only in IDLE.
- `abort`  in  1  synchronous cancel; highest priority after reset.
- `rd_addr`  out  `ADDR_LEN`  address to the register file read port (`src1`/`src2`).
- `rd_data`  in  `WORD_LEN`  combinational read data returned for `rd_addr`.
- `out_valid`  out  1  `out_data`/`out_index` hold a word.
- `out_ready`  in  1  consumer accepts the word when high with `out_valid`.
- `out_data`  out  `WORD_LEN`  captured register value.
- `out_index`  out  `ADDR_LEN`  register number of `out_data`.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse after the last word is accepted.

## Operation
- States:
  - IDLE: `busy`=0.
  - LOAD: drive `rd_addr`=`idx`; at the rising edge, register `rd_data` into `out_data` and `idx` into `out_index`.
  - SEND: `out_valid`=1.
  - DONE: `done`=1.
- Transitions:
  - IDLE→LOAD on `start`; clear `idx` to 0.
  - LOAD→SEND unconditionally.
  - SEND→LOAD on `out_ready` when `idx`≠`REG_COUNT`-1; increment `idx`.
  - SEND→DONE on `out_ready` when `idx`=`REG_COUNT`-1.
  - SEND stays in SEND while `out_ready`=0.
  - DONE→IDLE unconditionally.
- `rd_addr` = `idx` in all states, so it is 0 in IDLE.
- `idx` never wraps. The terminal compare happens before the increment, so no `ADDR_LEN` overflow occurs even when `REG_COUNT`=2^`ADDR_LEN`.
- While `out_valid`=1, `out_data` and `out_index` are stable until acceptance. The sole exception is `abort`.
- `abort` in any non-IDLE state: next state is IDLE, `out_valid` drops, and no `done` is pulsed. `abort` together with `start` in IDLE: stay in IDLE.
- `start` while `busy`: ignored, with no queueing.
- Values are not a snapshot. The register file writes on the falling edge, so a write on the falling edge before a LOAD rising edge is visible in that capture.

## Timing
- Reset values:
  - state IDLE, `idx`=0, `rd_addr`=0.
  - `out_valid`=0, `out_data`=0, `out_index`=0.
  - `busy`=0, `done`=0.
- All outputs are registered or decoded from state/`idx` only. There is no combinational path from `out_ready`, `start` or `abort` to any output.
- Latency: `start` sampled at edge N gives LOAD in cycle N+1 and first `out_valid` in cycle N+2.
- Throughput: one word per 2 cycles with `out_ready` held high. A full dump is `start` edge + 2×`REG_COUNT` cycles + 1 DONE cycle, which is 65 cycles from `start` to `done` for 32 registers.
- Back-pressure: each cycle of `out_ready`=0 in SEND adds exactly one cycle.
- Reset asserted mid-dump: all outputs return to reset values immediately (asynchronous). After release the block is in IDLE and requires a fresh `start`.

## Structure
- Widths come from the shared defines.v macros (`WORD_LEN`, `REG_FILE_ADDR_LEN`, `REG_FILE_SIZE`).
- State encoding is local to the module as 2-bit localparams and is not shared.
- No sub-module: a single FSM plus counter and output register.

## Test plan
- Preload register file r0..r31 with `value = 0x1000_0000 + i`. Pulse `start` with `out_ready`=1 → 32 words, index 0..31, data 0x1000_0000..0x1000_001F (r0 reads 0). Exactly one `done`, 65 cycles after `start`.
- Hold `out_ready`=0 for 5 cycles on index 7 → `out_valid` and `out_data`/`out_index` stay constant for 5 cycles, and total duration grows by 5.
- Write r9=0xDEADBEEF on the falling edge before LOAD of index 9 → word 9 reads 0xDEADBEEF.
- Assert `abort` during SEND of index 12 → next cycle IDLE, `out_valid`=0, `busy`=0, no `done`. A new `start` restarts at index 0.
- Pulse `start` while `busy` at index 3 → the sequence continues unchanged with a single `done`.
- Assert `rst` low mid-dump at index 20 → outputs go to zero asynchronously. After release, `busy`=0 and `rd_addr`=0.

Source files
------------

// File: rtl/reg_dump_reader_pkg.sv
// reg_dump_reader_pkg
// Shared defaults for the register-dump reader: word width, register address
// width and register count, mirroring the processor's register file sizing.
// Also holds a small helper used to detect the last register of a walk.
package reg_dump_reader_pkg;

  localparam int DEF_WORD_LEN  = 32;
  localparam int DEF_ADDR_LEN  = 5;
  localparam int DEF_REG_COUNT = 32;

  // True when idx addresses the final register of a walk over count registers.
  // Comparing against count-1 (instead of incrementing and comparing against
  // count) keeps the address counter from ever overflowing when
  // count == 2**addr_len.
  function automatic logic is_last_reg(input int unsigned idx, input int unsigned count);
    return (idx == (count - 32'd1));
  endfunction

endpackage

// File: rtl/reg_dump_reader_if.sv
// reg_dump_reader_if
// Bundles the dump control, register-file read port and output stream.
//   start/abort                  : dump request / cancel (into the reader)
//   rd_addr/rd_data              : register file read port
//   out_valid/out_ready          : output stream handshake
//   out_data/out_index           : streamed (value, register number)
//   busy/done                    : status
// modport master : the dump reader
// modport slave  : the environment (register file + consumer + controller)
interface reg_dump_reader_if #(
  parameter int WORD_LEN = 32,
  parameter int ADDR_LEN = 5
) ();

  logic                start;
  logic                abort;
  logic [ADDR_LEN-1:0] rd_addr;
  logic [WORD_LEN-1:0] rd_data;
  logic                out_valid;
  logic                out_ready;
  logic [WORD_LEN-1:0] out_data;
  logic [ADDR_LEN-1:0] out_index;
  logic                busy;
  logic                done;

  modport master (
    input  start, abort, rd_data, out_ready,
    output rd_addr, out_valid, out_data, out_index, busy, done
  );

  modport slave (
    output start, abort, rd_data, out_ready,
    input  rd_addr, out_valid, out_data, out_index, busy, done
  );

endinterface

// File: rtl/reg_dump_reader.sv
// reg_dump_reader
// Walks registers 0..REG_COUNT-1 through one combinational register-file read
// port and streams (index, value) pairs over a valid/ready handshake. Each word
// takes a LOAD cycle (address driven, value captured at the edge) followed by a
// SEND cycle (valid held until accepted). Never writes the register file.
// Ports:
//   clk  : sole clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : reg_dump_reader_if.master (start, abort, read port, stream, status)
module reg_dump_reader
  import reg_dump_reader_pkg::*;
#(
  parameter int WORD_LEN  = DEF_WORD_LEN,
  parameter int ADDR_LEN  = DEF_ADDR_LEN,
  parameter int REG_COUNT = DEF_REG_COUNT
) (
  input  logic               clk,
  input  logic               rst,
  reg_dump_reader_if.master  bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_SEND = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic [1:0]          state_r;
  logic [1:0]          state_next_s;
  logic [ADDR_LEN-1:0] idx_r;
  logic [ADDR_LEN-1:0] idx_next_s;
  logic [WORD_LEN-1:0] data_r;
  logic [ADDR_LEN-1:0] index_r;
  logic                last_s;

  assign last_s = is_last_reg(32'(idx_r), 32'(REG_COUNT));

  // State and register-index registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      idx_r   <= '0;
    end else begin
      state_r <= state_next_s;
      idx_r   <= idx_next_s;
    end
  end

  // Next-state and next-index logic; abort overrides every transition.
  always_comb begin
    state_next_s = state_r;
    idx_next_s   = idx_r;
    if (bus.abort) begin
      state_next_s = ST_IDLE;
      idx_next_s   = '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.start) begin
            state_next_s = ST_LOAD;
            idx_next_s   = '0;
          end else begin
            state_next_s = ST_IDLE;
          end
        end
        ST_LOAD: begin
          state_next_s = ST_SEND;
        end
        ST_SEND: begin
          if (bus.out_ready) begin
            if (last_s) begin
              state_next_s = ST_DONE;
            end else begin
              state_next_s = ST_LOAD;
              idx_next_s   = idx_r + ADDR_LEN'(1);
            end
          end else begin
            state_next_s = ST_SEND;
          end
        end
        ST_DONE: begin
          // Return the index to 0 so rd_addr reads 0 while idle.
          state_next_s = ST_IDLE;
          idx_next_s   = '0;
        end
        default: begin
          state_next_s = ST_IDLE;
          idx_next_s   = '0;
        end
      endcase
    end
  end

  // Output word register: captures the read port during LOAD only, so the
  // word stays frozen for the whole SEND phase regardless of back-pressure.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_r  <= '0;
      index_r <= '0;
    end else if ((state_r == ST_LOAD) && !bus.abort) begin
      data_r  <= bus.rd_data;
      index_r <= idx_r;
    end else begin
      data_r  <= data_r;
      index_r <= index_r;
    end
  end

  // Outputs decoded from registered state/index only.
  always_comb begin
    bus.rd_addr   = idx_r;
    bus.out_valid = (state_r == ST_SEND);
    bus.out_data  = data_r;
    bus.out_index = index_r;
    bus.busy      = (state_r != ST_IDLE);
    bus.done      = (state_r == ST_DONE);
  end

endmodule

// File: tb/tb_reg_dump_reader.sv
// tb_reg_dump_reader
// Directed bench for reg_dump_reader with a behavioural 32x32 register file
// (r0 hard-wired to zero, writes applied on the falling clock edge).
module tb_reg_dump_reader;

  logic clk;
  logic rst;
  int   vec;
  int   err;

  logic [31:0] regs [32];

  reg_dump_reader_if #(.WORD_LEN(32), .ADDR_LEN(5)) bus ();

  reg_dump_reader #(.WORD_LEN(32), .ADDR_LEN(5), .REG_COUNT(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.rd_data = (bus.rd_addr == 5'd0) ? 32'd0 : regs[bus.rd_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Results of the most recent drive_dump run.
  logic [31:0] cap_data  [32];
  logic [4:0]  cap_index [32];
  int nwords;
  int done_cnt;
  int done_cyc;
  int stall_cycles;
  int stall_changed;

  // Runs one dump from a start pulse, with optional stall, mid-dump register
  // write and start-while-busy pulse (-1 disables each). Cycle n is the cycle
  // after the n-th rising edge following the start pulse.
  task automatic drive_dump(input int stall_idx, input int stall_len, input int poke_idx,
                            input logic [31:0] poke_val, input int busy_idx, input int ncyc);
    int stall_left;
    logic [31:0] hold_d;
    logic [4:0]  hold_i;
    bit holding;
    bit busy_pulsed;
    nwords = 0; done_cnt = 0; done_cyc = -1; stall_cycles = 0; stall_changed = 0;
    stall_left = stall_len; holding = 0; busy_pulsed = 0;
    hold_d = '0; hold_i = '0;
    for (int i = 0; i < 32; i++) begin
      cap_data[i] = 32'hxxxx_xxxx;
      cap_index[i] = 5'bxxxxx;
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    bus.start = 1'b1;
    for (int cyc = 1; cyc <= ncyc; cyc++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.out_ready = 1'b1;
      if (bus.done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (bus.out_valid) begin
        if (holding && (bus.out_data !== hold_d || bus.out_index !== hold_i)) stall_changed++;
        if (stall_idx >= 0 && bus.out_index == stall_idx[4:0] && stall_left > 0) begin
          if (!holding) begin
            hold_d = bus.out_data;
            hold_i = bus.out_index;
            holding = 1;
          end
          bus.out_ready = 1'b0;
          stall_left--;
          stall_cycles++;
        end else begin
          holding = 0;
          if (nwords < 32) begin
            cap_data[nwords] = bus.out_data;
            cap_index[nwords] = bus.out_index;
          end
          nwords++;
        end
        if (busy_idx >= 0 && bus.out_index == busy_idx[4:0] && !busy_pulsed) begin
          bus.start = 1'b1;
          busy_pulsed = 1;
        end
      end else if (poke_idx >= 0 && bus.busy && !bus.done && bus.rd_addr == poke_idx[4:0]) begin
        @(negedge clk);
        regs[poke_idx] = poke_val;
      end
    end
  endtask

  // Starts a dump and advances until the word with index target is offered.
  task automatic run_to_index(input int target, output bit found);
    found = 0;
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    bus.start = 1'b1;
    for (int cyc = 1; cyc <= 80 && !found; cyc++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
      if (bus.out_valid && bus.out_index == target[4:0]) found = 1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.start = 1'b0; bus.abort = 1'b0; bus.out_ready = 1'b0;
    for (int i = 0; i < 32; i++) regs[i] = 32'h1000_0000 + 32'(i);
    repeat (3) @(posedge clk);
    #1;
    vec++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.out_valid !== 1'b0) begin
      err++;
      $display("FAIL reset_status: busy=%b done=%b valid=%b want 0 0 0", bus.busy, bus.done, bus.out_valid);
    end
    vec++;
    if (bus.out_data !== 32'd0 || bus.out_index !== 5'd0 || bus.rd_addr !== 5'd0) begin
      err++;
      $display("FAIL reset_data: data=%h index=%0d rd_addr=%0d want 0 0 0", bus.out_data, bus.out_index, bus.rd_addr);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vec++;
    if (bus.busy !== 1'b0 || bus.rd_addr !== 5'd0) begin
      err++;
      $display("FAIL idle_after_reset: busy=%b rd_addr=%0d want 0 0", bus.busy, bus.rd_addr);
    end
  endtask

  task automatic test_full_dump();
    logic [31:0] e;
    drive_dump(-1, 0, -1, 32'd0, -1, 75);
    vec++;
    if (nwords !== 32) begin
      err++;
      $display("FAIL full_word_count: got %0d want 32", nwords);
    end
    for (int i = 0; i < 32; i++) begin
      e = (i == 0) ? 32'd0 : 32'h1000_0000 + 32'(i);
      vec++;
      if (cap_index[i] !== 5'(i) || cap_data[i] !== e) begin
        err++;
        $display("FAIL full_word%0d: got idx=%0d data=%h want idx=%0d data=%h", i, cap_index[i], cap_data[i], i, e);
      end
    end
    vec++;
    if (done_cnt !== 1 || done_cyc !== 65) begin
      err++;
      $display("FAIL full_done: got count=%0d cycle=%0d want 1 65", done_cnt, done_cyc);
    end
  endtask

  task automatic test_backpressure();
    drive_dump(7, 5, -1, 32'd0, -1, 80);
    vec++;
    if (stall_cycles !== 5 || stall_changed !== 0) begin
      err++;
      $display("FAIL stall_hold: got stalls=%0d changes=%0d want 5 0", stall_cycles, stall_changed);
    end
    vec++;
    if (cap_index[7] !== 5'd7 || cap_data[7] !== 32'h1000_0007 || cap_data[8] !== 32'h1000_0008) begin
      err++;
      $display("FAIL stall_word7: got idx=%0d data=%h next=%h want 7 10000007 10000008", cap_index[7], cap_data[7], cap_data[8]);
    end
    vec++;
    if (nwords !== 32 || done_cnt !== 1 || done_cyc !== 70) begin
      err++;
      $display("FAIL stall_done: got words=%0d count=%0d cycle=%0d want 32 1 70", nwords, done_cnt, done_cyc);
    end
  endtask

  task automatic test_live_write();
    drive_dump(-1, 0, 9, 32'hDEAD_BEEF, -1, 75);
    vec++;
    if (cap_index[9] !== 5'd9 || cap_data[9] !== 32'hDEAD_BEEF) begin
      err++;
      $display("FAIL live_write9: got idx=%0d data=%h want 9 deadbeef", cap_index[9], cap_data[9]);
    end
    vec++;
    if (cap_data[8] !== 32'h1000_0008 || cap_data[10] !== 32'h1000_000A || done_cyc !== 65) begin
      err++;
      $display("FAIL live_neighbours: got r8=%h r10=%h done=%0d want 10000008 1000000a 65", cap_data[8], cap_data[10], done_cyc);
    end
    regs[9] = 32'h1000_0009;
  endtask

  task automatic test_abort();
    bit found;
    int dones;
    run_to_index(12, found);
    vec++;
    if (!found) begin
      err++;
      $display("FAIL abort_reach12: got no word 12 want word 12 offered");
    end
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    vec++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.rd_addr !== 5'd0) begin
      err++;
      $display("FAIL abort_idle: valid=%b busy=%b done=%b rd_addr=%0d want 0 0 0 0", bus.out_valid, bus.busy, bus.done, bus.rd_addr);
    end
    dones = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) dones++;
    end
    vec++;
    if (dones !== 0) begin
      err++;
      $display("FAIL abort_quiet: got %0d active cycles want 0", dones);
    end
    drive_dump(-1, 0, -1, 32'd0, -1, 75);
    vec++;
    if (cap_index[0] !== 5'd0 || cap_data[0] !== 32'd0 || nwords !== 32 || done_cnt !== 1) begin
      err++;
      $display("FAIL abort_restart: got idx0=%0d data0=%h words=%0d dones=%0d want 0 0 32 1", cap_index[0], cap_data[0], nwords, done_cnt);
    end
  endtask

  task automatic test_start_while_busy();
    drive_dump(-1, 0, -1, 32'd0, 3, 75);
    vec++;
    if (nwords !== 32 || done_cnt !== 1 || done_cyc !== 65) begin
      err++;
      $display("FAIL busy_start: got words=%0d dones=%0d cycle=%0d want 32 1 65", nwords, done_cnt, done_cyc);
    end
    vec++;
    if (cap_index[4] !== 5'd4 || cap_data[31] !== 32'h1000_001F || bus.busy !== 1'b0) begin
      err++;
      $display("FAIL busy_start_seq: got idx4=%0d data31=%h busy=%b want 4 1000001f 0", cap_index[4], cap_data[31], bus.busy);
    end
  endtask

  task automatic test_reset_mid_dump();
    bit found;
    run_to_index(20, found);
    vec++;
    if (!found || bus.out_data !== 32'h1000_0014) begin
      err++;
      $display("FAIL rst_reach20: found=%b data=%h want 1 10000014", found, bus.out_data);
    end
    #2;
    rst = 1'b0;
    #1;
    vec++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.out_data !== 32'd0 || bus.out_index !== 5'd0 || bus.rd_addr !== 5'd0) begin
      err++;
      $display("FAIL rst_async: valid=%b busy=%b data=%h idx=%0d rd_addr=%0d want all 0", bus.out_valid, bus.busy, bus.out_data, bus.out_index, bus.rd_addr);
    end
    @(negedge clk);
    rst = 1'b1;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vec++;
    if (bus.busy !== 1'b0 || bus.rd_addr !== 5'd0 || bus.out_valid !== 1'b0) begin
      err++;
      $display("FAIL rst_release: busy=%b rd_addr=%0d valid=%b want 0 0 0", bus.busy, bus.rd_addr, bus.out_valid);
    end
  endtask

  initial begin
    vec = 0;
    err = 0;
    test_reset();
    test_full_dump();
    test_backpressure();
    test_live_write();
    test_abort();
    test_start_while_busy();
    test_reset_mid_dump();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
